// File: rtl/fifo_word_packer_pkg.sv
// Shared definitions for the FIFO packing stages.
//   state_t    : controller state encoding (ACC = accumulating, FLUSH = flush pending)
//   DEF_WIDTH  : default upstream byte width
//   DEF_LANES  : default number of bytes per packed word
package fifo_word_packer_pkg;

    typedef enum logic {
        ACC   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LANES = 4;

endpackage

// File: rtl/fifo_word_packer.sv
// Packs bytes popped from an upstream synchronous FIFO into LANES-wide words.
// A flush pulse emits whatever partial word has been collected, with out_keep
// marking the filled lanes.
//
// State  | meaning
// -------+-----------------------------------------------------------
// ACC    | popping bytes into acc, emitting full words
// FLUSH  | partial word pending, waiting for a free output slot
//
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous reset, active-high
//   fifo_empty  : upstream FIFO empty flag
//   fifo_dout   : upstream FIFO read data (valid while fifo_rd_en=1)
//   fifo_rd_en  : upstream FIFO pop request (combinational)
//   flush       : single-cycle request to emit a partial word
//   out_data    : packed word, lane 0 in the low bits
//   out_keep    : per-lane valid mask
//   out_valid   : word available
//   out_ready   : downstream accepts the word
module fifo_word_packer
    import fifo_word_packer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    input  logic [WIDTH-1:0]       fifo_dout,
    output logic                   fifo_rd_en,
    input  logic                   flush,
    output logic [WIDTH*LANES-1:0] out_data,
    output logic [LANES-1:0]       out_keep,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int CW = $clog2(LANES);
    localparam int DW = WIDTH * LANES;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   acc, acc_nxt, acc_wr, data_nxt;
    logic [LANES-1:0] keep_nxt, flush_keep;
    logic            valid_nxt;
    logic            slot_free, xfer, last_lane, pop;

    assign slot_free  = ~out_valid | out_ready;
    assign xfer       = out_valid & out_ready;
    assign last_lane  = (cnt == CW'(LANES - 1));
    // The last lane is only popped when the completed word has somewhere to go.
    assign pop        = ~rst & (state == ACC) & ~fifo_empty & ~(last_lane & ~slot_free);
    assign fifo_rd_en = pop;

    // acc with the incoming byte written into lane cnt, plus the partial keep mask.
    always_comb begin
        acc_wr     = acc;
        flush_keep = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cnt == CW'(i)) begin
                acc_wr[i*WIDTH +: WIDTH] = fifo_dout;
            end
            flush_keep[i] = (i < int'(cnt));
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        data_nxt  = out_data;
        keep_nxt  = out_keep;
        valid_nxt = out_valid;

        if (xfer) begin
            valid_nxt = 1'b0;
        end

        case (state)
            ACC: begin
                if (pop) begin
                    if (last_lane) begin
                        // Word completes on this pop; a simultaneous flush has nothing left to do.
                        data_nxt  = acc_wr;
                        keep_nxt  = '1;
                        valid_nxt = 1'b1;
                        cnt_nxt   = '0;
                        acc_nxt   = '0;
                    end else begin
                        acc_nxt = acc_wr;
                        cnt_nxt = cnt + CW'(1);
                        if (flush) begin
                            state_nxt = FLUSH;
                        end
                    end
                end else if (flush && (cnt != '0)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (slot_free) begin
                    // Unused lanes of acc are already zero since acc is cleared per word.
                    data_nxt  = acc;
                    keep_nxt  = flush_keep;
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    acc_nxt   = '0;
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACC;
            cnt       <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            out_data  <= data_nxt;
            out_keep  <= keep_nxt;
            out_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: directed scenarios with literal
// expectations, then randomized traffic checked against a byte-queue model.
module tb_fifo_word_packer;
    import fifo_word_packer_pkg::*;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int DW    = WIDTH * LANES;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fifo_empty = 1'b1;
    logic [WIDTH-1:0] fifo_dout = '0;
    logic             fifo_rd_en;
    logic             flush = 1'b0;
    logic [DW-1:0]    out_data;
    logic [LANES-1:0] out_keep;
    logic             out_valid;
    logic             out_ready = 1'b1;

    fifo_word_packer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .flush      (flush),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Upstream FIFO contents
    logic [WIDTH-1:0] fifo_q[$];

    // Model: bytes collected so far, flush-pending flag, output register
    logic [WIDTH-1:0] acc_q[$];
    bit               m_pend = 0;
    bit               m_valid = 0;
    logic [DW-1:0]    m_data = '0;
    logic [LANES-1:0] m_keep = '0;

    bit               started = 0;
    bit               dut_pop_s = 0;
    int               valid_cycles = 0;
    logic [DW+LANES-1:0] xlog[$];

    function automatic logic [DW-1:0] pack(input int n);
        logic [DW-1:0] w = '0;
        for (int i = 0; i < n; i++) w[i*WIDTH +: WIDTH] = acc_q[i];
        return w;
    endfunction

    function automatic bit model_pop();
        if (rst || m_pend || fifo_empty) return 0;
        if (acc_q.size() == LANES - 1 && m_valid && !out_ready) return 0;
        return 1;
    endfunction

    // Compare process: all DUT outputs against the model, away from the edge.
    always @(negedge clk) begin
        if (started) begin
            chk("rd_en", 64'(fifo_rd_en), 64'(model_pop()));
            chk("valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("data", 64'(out_data), 64'(m_data));
                chk("keep", 64'(out_keep), 64'(m_keep));
            end
            if (out_valid === 1'b1) valid_cycles++;
            if (out_valid === 1'b1 && out_ready && !rst) xlog.push_back({out_data, out_keep});
        end
        dut_pop_s = (fifo_rd_en === 1'b1);
    end

    // Model advance and FIFO pop on each rising edge.
    always @(posedge clk) begin
        bit pop, xfer, slot, loaded;
        pop    = model_pop();
        xfer   = m_valid && out_ready;
        slot   = !m_valid || out_ready;
        loaded = 0;
        if (rst) begin
            acc_q.delete();
            m_pend  = 0;
            m_valid = 0;
            m_data  = '0;
            m_keep  = '0;
        end else begin
            if (!m_pend) begin
                if (pop) begin
                    acc_q.push_back(fifo_dout);
                    if (acc_q.size() == LANES) begin
                        m_data = pack(LANES);
                        m_keep = '1;
                        loaded = 1;
                        acc_q.delete();
                    end else if (flush) begin
                        m_pend = 1;
                    end
                end else if (flush && acc_q.size() > 0) begin
                    m_pend = 1;
                end
            end else if (slot) begin
                m_data = pack(acc_q.size());
                m_keep = LANES'((1 << acc_q.size()) - 1);
                loaded = 1;
                acc_q.delete();
                m_pend = 0;
            end
            if (loaded) m_valid = 1;
            else if (xfer) m_valid = 0;
        end
        if (dut_pop_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
        started = 1;
    end

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [WIDTH-1:0] b);
        fifo_q.push_back(b);
        refresh();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        refresh();
    endtask

    task automatic clear_log();
        xlog.delete();
        valid_cycles = 0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_keep", 64'(out_keep), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        rst = 1'b0;
        cyc();

        // Four bytes, ready high: one full word, valid for one cycle
        clear_log();
        out_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        repeat (8) cyc();
        chk("t1_words", 64'(xlog.size()), 64'd1);
        if (xlog.size() > 0) chk("t1_word", 64'(xlog[0]), 64'({32'h44332211, 4'b1111}));
        chk("t1_vcycles", 64'(valid_cycles), 64'd1);

        // Eight bytes with backpressure on the first word
        clear_log();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (10) cyc();
        chk("t2_words_held", 64'(xlog.size()), 64'd0);
        chk("t2_hold_valid", 64'(out_valid), 64'd1);
        chk("t2_hold_data", 64'(out_data), 64'h04030201);
        chk("t2_rd_en_off", 64'(fifo_rd_en), 64'd0);
        chk("t2_cnt", 64'(dut.cnt), 64'd3);
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("t2_words", 64'(xlog.size()), 64'd2);
        if (xlog.size() > 1) begin
            chk("t2_word0", 64'(xlog[0]), 64'({32'h04030201, 4'b1111}));
            chk("t2_word1", 64'(xlog[1]), 64'({32'h08070605, 4'b1111}));
        end
        chk("t2_fifo_drained", 64'(fifo_q.size()), 64'd0);

        // Partial word via flush; FIFO must not be popped while flushing
        clear_log();
        push(8'hAA); push(8'hBB);
        cyc(); cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        push(8'hCC);
        #1;
        chk("t3_state", 64'(dut.state), 64'(FLUSH));
        chk("t3_rd_en_flush", 64'(fifo_rd_en), 64'd0);
        cyc();
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        repeat (4) cyc();
        chk("t3_words", 64'(xlog.size()), 64'd2);
        if (xlog.size() > 1) begin
            chk("t3_word0", 64'(xlog[0]), 64'({32'h0000BBAA, 4'b0011}));
            chk("t3_word1", 64'(xlog[1]), 64'({32'h000000CC, 4'b0001}));
        end

        // Flush with nothing collected is ignored
        clear_log();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t4_state", 64'(dut.state), 64'(ACC));
        repeat (3) cyc();
        chk("t4_words", 64'(xlog.size()), 64'd0);
        chk("t4_valid", 64'(out_valid), 64'd0);

        // Flush coinciding with the fourth pop: full word only
        clear_log();
        push(8'h5A); push(8'h6B); push(8'h7C); push(8'h8D);
        repeat (3) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t5_state", 64'(dut.state), 64'(ACC));
        repeat (4) cyc();
        chk("t5_words", 64'(xlog.size()), 64'd1);
        if (xlog.size() > 0) chk("t5_word", 64'(xlog[0]), 64'({32'h8D7C6B5A, 4'b1111}));

        // Reset mid-word, then a clean word
        clear_log();
        push(8'hA1); push(8'hA2);
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_cnt", 64'(dut.cnt), 64'd0);
        rst = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        repeat (8) cyc();
        chk("t6_words", 64'(xlog.size()), 64'd1);
        if (xlog.size() > 0) chk("t6_word", 64'(xlog[0]), 64'({32'hC4C3C2C1, 4'b1111}));

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if (fifo_q.size() < 16 && $urandom_range(0, 1) == 1) push(8'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            cyc();
        end
        flush = 1'b0;
        rst   = 1'b0;
        out_ready = 1'b1;
        repeat (40) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
